predictor_update_scheduler: RTL and testbench

Sits between the Reorder Buffer commit stage and the branch predictor's single update port. After reset it sequences an initialisation sweep that writes every predictor counter to weakly-not-taken (2'b01). It then queues committed-branch outcomes from two ROB commit ports and drains them to the predictor at one update per cycle. Fetch uses initDone to gate prediction use.

---
 rtl/predictor_update_scheduler_pkg.sv | 33 +++
 rtl/predictor_update_fifo.sv | 79 +++++++
 rtl/predictor_update_scheduler.sv | 143 ++++++++++++++
 tb/tb_predictor_update_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/predictor_update_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// predictor_update_scheduler_pkg
// Shared types and constants for the branch-predictor update scheduler.
//   sched_state_t   : scheduler FSM encoding (ST_INIT sweep, ST_RUN drain)
//   upd_entry_t     : one queued predictor update {instr, taken}
//   PRED_INIT_VALUE : counter value the predictor writes on an initWrite
//   pred_index()    : predictor table index taken from a branch address
// ---------------------------------------------------------------------------
package predictor_update_scheduler_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    // Weakly-not-taken; the predictor substitutes this value whenever
    // initWrite is high instead of stepping the counter.
    localparam logic [1:0] PRED_INIT_VALUE = 2'b01;

    localparam int PRED_LOCAL_WIDTH = 12;

    typedef struct packed {
        logic [31:0] instr;
        logic        taken;
    } upd_entry_t;

    // Instructions are word aligned, so the low two address bits carry no
    // information and the index starts at bit 2.
    function automatic logic [PRED_LOCAL_WIDTH-1:0] pred_index(input logic [31:0] addr);
        return addr[PRED_LOCAL_WIDTH+1:2];
    endfunction

endpackage

// File: rtl/predictor_update_fifo.sv
// ---------------------------------------------------------------------------
// predictor_update_fifo
// Circular buffer with two write ports and one read port holding pending
// predictor updates. Port 0 is older than port 1; when both write in the
// same cycle port 0 lands at tail and port 1 at tail+1. When only port 1
// writes it takes the tail slot, so no hole is ever left in the queue.
//   i_clk, i_srst         : clock, synchronous active-high reset
//   i_push0, i_push0_data : older write port
//   i_push1, i_push1_data : younger write port
//   i_pop                 : remove the head entry (ignored when empty)
//   o_head_data           : current head entry (combinational read)
//   o_count               : number of valid entries, 0..DEPTH
// The caller guarantees free space before pushing.
// ---------------------------------------------------------------------------
module predictor_update_fifo
    import predictor_update_scheduler_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_srst,
    input  logic          i_push0,
    input  upd_entry_t    i_push0_data,
    input  logic          i_push1,
    input  upd_entry_t    i_push1_data,
    input  logic          i_pop,
    output upd_entry_t    o_head_data,
    output logic [CW-1:0] o_count
);

    upd_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_slot0_we;
    upd_entry_t    w_slot0_data;
    logic          w_slot1_we;
    logic [AW-1:0] w_tail_plus1;
    logic [CW-1:0] w_n_push;
    logic          w_pop;

    // Slot 0 is the tail slot, filled by whichever port is the older valid one.
    assign w_slot0_we   = i_push0 | i_push1;
    assign w_slot0_data = i_push0 ? i_push0_data : i_push1_data;
    assign w_slot1_we   = i_push0 & i_push1;
    // DEPTH is a power of two, so the AW-bit add wraps modulo DEPTH.
    assign w_tail_plus1 = r_tail + AW'(1);
    assign w_n_push     = CW'(i_push0) + CW'(i_push1);
    assign w_pop        = i_pop && (r_count != '0);

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_slot0_we) begin
            r_mem[r_tail] <= w_slot0_data;
        end
        if (w_slot1_we) begin
            r_mem[w_tail_plus1] <= i_push1_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + AW'(w_n_push);
            r_head  <= r_head + AW'(w_pop);
            r_count <= r_count + w_n_push - CW'(w_pop);
        end
    end

    assign o_head_data = r_mem[r_head];
    assign o_count     = r_count;

endmodule

// File: rtl/predictor_update_scheduler.sv
// ---------------------------------------------------------------------------
// predictor_update_scheduler
// Feeds the branch predictor's single update port. After reset it sweeps
// the whole table writing weakly-not-taken, then queues resolved branches
// from the two ROB commit ports and drains them one per cycle.
//   clockIn, resetIn     : clock, synchronous active-high reset
//   commitValid0/1       : commit port carries a resolved branch (1 younger)
//   commitInstr0/1       : branch instruction address
//   commitTaken0/1       : resolved direction
//   commitReady          : both commit ports may present an entry this cycle
//   updateValid          : registered update strobe to the predictor
//   updateInstr, taken   : update address / direction ({index,2'b00},0 in init)
//   initWrite            : predictor writes its init value instead of stepping
//   initDone             : sweep finished, predictions are usable
//   overflowErr          : sticky, a commit was presented while not ready
// ---------------------------------------------------------------------------
module predictor_update_scheduler
    import predictor_update_scheduler_pkg::*;
#(
    parameter int LOCAL_WIDTH = PRED_LOCAL_WIDTH,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        commitValid0,
    input  logic [31:0] commitInstr0,
    input  logic        commitTaken0,
    input  logic        commitValid1,
    input  logic [31:0] commitInstr1,
    input  logic        commitTaken1,
    output logic        commitReady,
    output logic        updateValid,
    output logic [31:0] updateInstr,
    output logic        taken,
    output logic        initWrite,
    output logic        initDone,
    output logic        overflowErr
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    // Two slots must be free so both ports can always be absorbed at once.
    localparam logic [CW-1:0] READY_LIMIT = CW'(QUEUE_DEPTH - 2);

    sched_state_t           r_state;
    logic [LOCAL_WIDTH-1:0] r_index;
    logic                   r_update_valid;
    logic [31:0]            r_update_instr;
    logic                   r_taken;
    logic                   r_init_write;
    logic                   r_init_done;
    logic                   r_overflow_err;

    logic [CW-1:0]          w_fifo_count;
    upd_entry_t             w_head;
    upd_entry_t             w_entry0;
    upd_entry_t             w_entry1;
    logic                   w_commit_ready;
    logic                   w_push0;
    logic                   w_push1;
    logic                   w_pop;
    logic                   w_sweep_last;
    logic [31:0]            w_sweep_addr;
    logic                   w_drop;

    assign w_commit_ready = (r_state == ST_RUN) && (w_fifo_count <= READY_LIMIT);
    assign w_push0        = commitValid0 & w_commit_ready;
    assign w_push1        = commitValid1 & w_commit_ready;
    assign w_pop          = (r_state == ST_RUN) && (w_fifo_count != '0);
    assign w_drop         = (commitValid0 | commitValid1) & ~w_commit_ready;

    assign w_entry0 = '{instr: commitInstr0, taken: commitTaken0};
    assign w_entry1 = '{instr: commitInstr1, taken: commitTaken1};

    assign w_sweep_last = (r_index == {LOCAL_WIDTH{1'b1}});
    assign w_sweep_addr = {{(30 - LOCAL_WIDTH){1'b0}}, r_index, 2'b00};

    predictor_update_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .i_clk        (clockIn),
        .i_srst       (resetIn),
        .i_push0      (w_push0),
        .i_push0_data (w_entry0),
        .i_push1      (w_push1),
        .i_push1_data (w_entry1),
        .i_pop        (w_pop),
        .o_head_data  (w_head),
        .o_count      (w_fifo_count)
    );

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            r_state        <= ST_INIT;
            r_index        <= '0;
            r_update_valid <= 1'b0;
            r_update_instr <= '0;
            r_taken        <= 1'b0;
            r_init_write   <= 1'b0;
            r_init_done    <= 1'b0;
            r_overflow_err <= 1'b0;
        end else begin
            r_overflow_err <= r_overflow_err | w_drop;
            case (r_state)
                ST_INIT: begin
                    r_update_valid <= 1'b1;
                    r_init_write   <= 1'b1;
                    r_taken        <= 1'b0;
                    r_update_instr <= w_sweep_addr;
                    r_index        <= r_index + LOCAL_WIDTH'(1);
                    if (w_sweep_last) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The predictor reads its own registered counters, so
                    // repeated updates to one index can go back-to-back.
                    r_init_done    <= 1'b1;
                    r_init_write   <= 1'b0;
                    r_update_valid <= w_pop;
                    if (w_pop) begin
                        r_update_instr <= w_head.instr;
                        r_taken        <= w_head.taken;
                    end else begin
                        r_update_instr <= '0;
                        r_taken        <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign commitReady = w_commit_ready;
    assign updateValid = r_update_valid;
    assign updateInstr = r_update_instr;
    assign taken       = r_taken;
    assign initWrite   = r_init_write;
    assign initDone    = r_init_done;
    assign overflowErr = r_overflow_err;

endmodule

// File: tb/tb_predictor_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_predictor_update_scheduler
// Directed bench for predictor_update_scheduler with LOCAL_WIDTH=4 and
// QUEUE_DEPTH=8. Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_predictor_update_scheduler;

    logic        clockIn = 1'b0;
    logic        resetIn = 1'b1;
    logic        commitValid0 = 1'b0;
    logic [31:0] commitInstr0 = '0;
    logic        commitTaken0 = 1'b0;
    logic        commitValid1 = 1'b0;
    logic [31:0] commitInstr1 = '0;
    logic        commitTaken1 = 1'b0;
    logic        commitReady;
    logic        updateValid;
    logic [31:0] updateInstr;
    logic        taken;
    logic        initWrite;
    logic        initDone;
    logic        overflowErr;

    int vectors     = 0;
    int miscompares = 0;

    logic [32:0] exp_q[$];

    always #5 clockIn = ~clockIn;

    predictor_update_scheduler #(
        .LOCAL_WIDTH (4),
        .QUEUE_DEPTH (8)
    ) dut (
        .clockIn      (clockIn),
        .resetIn      (resetIn),
        .commitValid0 (commitValid0),
        .commitInstr0 (commitInstr0),
        .commitTaken0 (commitTaken0),
        .commitValid1 (commitValid1),
        .commitInstr1 (commitInstr1),
        .commitTaken1 (commitTaken1),
        .commitReady  (commitReady),
        .updateValid  (updateValid),
        .updateInstr  (updateInstr),
        .taken        (taken),
        .initWrite    (initWrite),
        .initDone     (initDone),
        .overflowErr  (overflowErr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clockIn);
        #1;
    endtask

    // Compare the current update against the oldest expected entry.
    task automatic check_update(input string tag);
        logic [32:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
        check({tag, "_instr"}, updateInstr, e[32:1]);
        check({tag, "_taken"}, 32'(taken), 32'(e[0]));
        $display("txn update instr=0x%08h taken=%0d", updateInstr, taken);
    endtask

    // Full 16-entry sweep; optionally presents a commit on the first INIT cycle.
    task automatic sweep(input bit inject);
        if (inject) begin
            commitValid0 = 1'b1;
            commitInstr0 = 32'h0000_ABC0;
            commitTaken0 = 1'b1;
        end
        for (int k = 0; k < 16; k++) begin
            step();
            commitValid0 = 1'b0;
            check("sweep_valid",    32'(updateValid), 32'd1);
            check("sweep_initwr",   32'(initWrite),   32'd1);
            check("sweep_addr",     updateInstr,      32'(k * 4));
            check("sweep_taken",    32'(taken),       32'd0);
            check("sweep_initdone", 32'(initDone),    32'd0);
            check("sweep_ready",    32'(commitReady), (k == 15) ? 32'd1 : 32'd0);
            check("sweep_ovf",      32'(overflowErr), 32'(inject));
            $display("txn sweep index=%0d addr=0x%08h", k, updateInstr);
        end
        step();
        check("run_initdone", 32'(initDone),    32'd1);
        check("run_valid",    32'(updateValid), 32'd0);
        check("run_initwr",   32'(initWrite),   32'd0);
        check("run_ready",    32'(commitReady), 32'd1);
    endtask

    initial begin
        logic [9:0] rdy_tab;

        // Reset state
        step(); step(); step();
        check("rst_valid",    32'(updateValid), 32'd0);
        check("rst_instr",    updateInstr,      32'd0);
        check("rst_taken",    32'(taken),       32'd0);
        check("rst_initwr",   32'(initWrite),   32'd0);
        check("rst_initdone", 32'(initDone),    32'd0);
        check("rst_ovf",      32'(overflowErr), 32'd0);
        check("rst_ready",    32'(commitReady), 32'd0);

        // Initialisation sweep
        resetIn = 1'b0;
        sweep(1'b0);

        // Both ports in one cycle
        commitValid0 = 1'b1; commitInstr0 = 32'h100; commitTaken0 = 1'b1;
        commitValid1 = 1'b1; commitInstr1 = 32'h204; commitTaken1 = 1'b0;
        exp_q.push_back({32'h100, 1'b1});
        exp_q.push_back({32'h204, 1'b0});
        step();
        commitValid0 = 1'b0; commitValid1 = 1'b0;
        check("pair_latency", 32'(updateValid), 32'd0);
        step();
        check("pair0_valid", 32'(updateValid), 32'd1);
        check_update("pair0");
        step();
        check("pair1_valid", 32'(updateValid), 32'd1);
        check_update("pair1");
        step();
        check("pair_idle", 32'(updateValid), 32'd0);

        // Port 1 only
        commitValid1 = 1'b1; commitInstr1 = 32'h08; commitTaken1 = 1'b1;
        exp_q.push_back({32'h08, 1'b1});
        step();
        commitValid1 = 1'b0;
        check("p1_latency", 32'(updateValid), 32'd0);
        step();
        check("p1_valid", 32'(updateValid), 32'd1);
        check_update("p1");
        step();
        check("p1_idle",  32'(updateValid), 32'd0);
        check("p1_ready", 32'(commitReady), 32'd1);

        // Two pushes per cycle for 10 cycles: queue fills to 7, ready toggles
        rdy_tab = 10'b10_1011_1111;
        for (int c = 0; c < 10; c++) begin
            check("burst_ready", 32'(commitReady), 32'(rdy_tab[c]));
            commitValid0 = 1'b1; commitInstr0 = 32'h1000 + 32'(c * 8); commitTaken0 = 1'(c % 2);
            commitValid1 = 1'b1; commitInstr1 = 32'h1004 + 32'(c * 8); commitTaken1 = ~1'(c % 2);
            if (rdy_tab[c]) begin
                exp_q.push_back({commitInstr0, commitTaken0});
                exp_q.push_back({commitInstr1, commitTaken1});
            end
            step();
            check("burst_valid", 32'(updateValid), (c != 0) ? 32'd1 : 32'd0);
            if (updateValid) check_update("burst");
        end
        commitValid0 = 1'b0; commitValid1 = 1'b0;
        check("burst_ovf", 32'(overflowErr), 32'd1);
        for (int n = 0; n < 30 && exp_q.size() > 0; n++) begin
            step();
            check("drain_valid", 32'(updateValid), 32'd1);
            check_update("drain");
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        step();
        check("drain_idle",  32'(updateValid), 32'd0);
        check("drain_ready", 32'(commitReady), 32'd1);
        check("drain_ovf",   32'(overflowErr), 32'd1);

        // Queue 5 entries, then reset mid-drain
        for (int c = 0; c < 4; c++) begin
            commitValid0 = 1'b1; commitInstr0 = 32'h3000 + 32'(c * 8); commitTaken0 = 1'b1;
            commitValid1 = 1'b1; commitInstr1 = 32'h3004 + 32'(c * 8); commitTaken1 = 1'b0;
            step();
        end
        commitValid0 = 1'b0; commitValid1 = 1'b0;
        check("fill_valid", 32'(updateValid), 32'd1);
        resetIn = 1'b1;
        step();
        check("mid_rst_valid",    32'(updateValid), 32'd0);
        check("mid_rst_instr",    updateInstr,      32'd0);
        check("mid_rst_initdone", 32'(initDone),    32'd0);
        check("mid_rst_ready",    32'(commitReady), 32'd0);
        check("mid_rst_ovf",      32'(overflowErr), 32'd0);
        resetIn = 1'b0;

        // Restarted sweep with a commit presented during INIT
        sweep(1'b1);
        for (int n = 0; n < 4; n++) begin
            step();
            check("post_stale_valid", 32'(updateValid), 32'd0);
            check("post_ovf",         32'(overflowErr), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
